// File: rtl/rx_pkt_rd_ctrl.sv
// Packet read controller: fetches a packet from a 2-cycle-latency RAM and
// streams it out through a 4-entry credit-managed FIFO with sop/eop framing.
module rx_pkt_rd_ctrl #(
    parameter int unsigned ADDR_DEPTH = 2048,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] pkt_base,
    input  logic [ADDR_WIDTH-1:0] pkt_len,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_sop,
    output logic                  tx_eop,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CNT_W      = ADDR_WIDTH + 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned OCC_W      = 3;
    localparam int unsigned CRD_W      = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       len_q, len_d;
    logic [CNT_W-1:0]       issued_q, issued_d;
    logic [CNT_W-1:0]       sent_q, sent_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   ram_en_q, ram_en_d;
    logic                   rd_p1_q, rd_p2_q;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       count_q, count_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   tx_sop_q, tx_sop_d;
    logic                   tx_eop_q, tx_eop_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   push, pop;
    logic [CRD_W-1:0]       credit_used;
    logic                   can_issue;
    logic [ADDR_WIDTH-1:0]  addr_inc;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            addr_q     <= '0;
            ram_en_q   <= 1'b0;
            rd_p1_q    <= 1'b0;
            rd_p2_q    <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            addr_q     <= addr_d;
            ram_en_q   <= ram_en_d;
            rd_p1_q    <= ram_en_q;
            rd_p2_q    <= rd_p1_q;
            if (push) begin
                mem_q[wr_ptr_q] <= ram_dout;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_valid_q <= tx_valid_d;
            tx_sop_q   <= tx_sop_d;
            tx_eop_q   <= tx_eop_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state, read issue and FIFO bookkeeping
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        addr_d   = addr_q;
        ram_en_d = 1'b0;

        // rd_p2_q marks the cycle ram_dout carries the data of an earlier issue
        push     = rd_p2_q;
        pop      = tx_valid_q & tx_ready;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + OCC_W'(push) - OCC_W'(pop);
        sent_d   = sent_q + CNT_W'(pop);

        // Credit counts next-cycle FIFO occupancy plus reads still in the RAM pipe
        credit_used = CRD_W'(count_d) + CRD_W'(ram_en_q) + CRD_W'(rd_p1_q);
        can_issue   = (credit_used < CRD_W'(FIFO_DEPTH));
        addr_inc    = (addr_q == ADDR_WIDTH'(ADDR_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

        unique case (state_q)
            S_IDLE: begin
                if (start && (pkt_len != '0)) begin
                    state_d  = S_RUN;
                    len_d    = CNT_W'(pkt_len);
                    issued_d = CNT_W'(1);
                    sent_d   = '0;
                    addr_d   = pkt_base;
                    ram_en_d = 1'b1;
                end
            end
            S_RUN: begin
                if (issued_q == len_q) begin
                    state_d = S_DRAIN;
                end else if (can_issue) begin
                    ram_en_d = 1'b1;
                    issued_d = issued_q + CNT_W'(1);
                    addr_d   = addr_inc;
                end
            end
            S_DRAIN: begin
                if (pop && tx_eop_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Head of FIFO after this cycle's pop/push; bypass when it was empty
        tx_valid_d = (count_d != '0);
        if (push && ((count_q - OCC_W'(pop)) == '0)) begin
            tx_data_d = ram_dout;
        end else begin
            tx_data_d = mem_q[rd_ptr_d];
        end
        tx_sop_d = tx_valid_d && (sent_d == '0);
        tx_eop_d = tx_valid_d && (sent_d == (len_d - CNT_W'(1)));

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    assign ram_en   = ram_en_q;
    assign ram_we   = 1'b0;
    assign ram_addr = addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_sop   = tx_sop_q;
    assign tx_eop   = tx_eop_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
